// File: rtl/fifo_seu_pkg.sv
// Shared sizing for the SEU-hardened Gray-code dual-clock FIFO pointer logic.
package fifo_seu_pkg;

  localparam int unsigned ADDRSIZE_DEF = 3;
  localparam int unsigned PTRSIZE      = ADDRSIZE_DEF + 1;
  localparam int unsigned SEU_CNT_W    = 8;

endpackage

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 majority voter for triplicated registers.
module tmr_vote #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/wptr_full_seu.sv
// Write pointer and full flag for the Gray-code async FIFO, with TMR on both pointers.
// Define WPTR_SEU_MON_EN to add the seu_det / seu_cnt upset monitor outputs.
module wptr_full_seu
  import fifo_seu_pkg::*;
#(
  parameter int unsigned ADDRSIZE = ADDRSIZE_DEF
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 winc,
  input  logic [ADDRSIZE:0]    wq2_rptr,
  output logic [ADDRSIZE-1:0]  waddr,
  output logic [ADDRSIZE:0]    wptr,
`ifdef WPTR_SEU_MON_EN
  output logic                 seu_det,
  output logic [SEU_CNT_W-1:0] seu_cnt,
`endif
  output logic                 wfull
);

  localparam int unsigned PtrSize = ADDRSIZE + 1;

  logic [PtrSize-1:0] wbin_q0, wbin_q1, wbin_q2;
  logic [PtrSize-1:0] wptr_q0, wptr_q1, wptr_q2;
  logic [PtrSize-1:0] wbin_v, wptr_v;
  logic [PtrSize-1:0] wbinnext, wgraynext;
  logic               wfull_q, wfull_val;

  tmr_vote #(
    .WIDTH(PtrSize)
  ) u_vote_bin (
    .a(wbin_q0),
    .b(wbin_q1),
    .c(wbin_q2),
    .y(wbin_v)
  );

  tmr_vote #(
    .WIDTH(PtrSize)
  ) u_vote_gray (
    .a(wptr_q0),
    .b(wptr_q1),
    .c(wptr_q2),
    .y(wptr_v)
  );

  always_comb begin
    wbinnext  = wbin_v + {{(PtrSize-1){1'b0}}, winc & ~wfull_q};
    wgraynext = (wbinnext >> 1) ^ wbinnext;
    // Full when next pointer has lapped the read pointer: top two Gray bits inverted.
    wfull_val = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
  end

  // All copies reload from the voted next value each edge, scrubbing any upset.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q0 <= '0;
      wbin_q1 <= '0;
      wbin_q2 <= '0;
      wptr_q0 <= '0;
      wptr_q1 <= '0;
      wptr_q2 <= '0;
      wfull_q <= 1'b0;
    end else begin
      wbin_q0 <= wbinnext;
      wbin_q1 <= wbinnext;
      wbin_q2 <= wbinnext;
      wptr_q0 <= wgraynext;
      wptr_q1 <= wgraynext;
      wptr_q2 <= wgraynext;
      wfull_q <= wfull_val;
    end
  end

  assign waddr = wbin_v[ADDRSIZE-1:0];
  assign wptr  = wptr_v;
  assign wfull = wfull_q;

`ifdef WPTR_SEU_MON_EN
  logic                 seu_now;
  logic                 seu_det_q;
  logic [SEU_CNT_W-1:0] seu_cnt_q;

  always_comb begin
    seu_now = |((wbin_q0 ^ wbin_v) | (wbin_q1 ^ wbin_v) | (wbin_q2 ^ wbin_v) |
                (wptr_q0 ^ wptr_v) | (wptr_q1 ^ wptr_v) | (wptr_q2 ^ wptr_v));
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      seu_det_q <= 1'b0;
      seu_cnt_q <= '0;
    end else begin
      seu_det_q <= seu_now;
      if (seu_det_q && (seu_cnt_q != '1)) begin
        seu_cnt_q <= seu_cnt_q + SEU_CNT_W'(1);
      end
    end
  end

  assign seu_det = seu_det_q;
  assign seu_cnt = seu_cnt_q;
`endif

endmodule
